// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: access-size encodings, FSM states and lane helpers
// shared by the mem_responder memory model.
package mem_resp_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    MERGE,
    RESP
  } state_t;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] s);
    logic [31:0] m;
    case (s)
      SZ_HALF: m = 32'h0000_FFFF;
      SZ_BYTE: m = 32'h0000_00FF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: datapath memory-port bundle with
// master (datapath) and slave (memory) views.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, size, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, size, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_bank.sv
// mem_bank: word storage, synchronous write, combinational read,
// single shared address port; contents survive reset.
module mem_bank #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle word/half/byte memory responder.
// Define MEM_RESP_ERR_EN to flag misaligned accesses instead of aligning.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] W_LAST =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t        r_state, w_next, w_after;
  logic [3:0]    r_cnt;
  logic          r_we, r_err;
  logic [1:0]    r_size;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata, r_rdata;

  logic          w_we, w_err, w_sub, w_mem_we;
  logic          w_unused;
  logic [1:0]    w_size;
  logic [AW+1:0] w_addr;
  logic [4:0]    w_sh;
  logic [31:0]   w_wdata, w_mask, w_mem_rd;
  logic [31:0]   w_mem_wd, w_lane_rd;

  assign w_unused = ^bus.addr[31:AW+2];

  // In IDLE the live bus is the access; afterwards the captured copy.
  always_comb begin
    w_we    = r_we;
    w_size  = r_size;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_err   = r_err;
    if (r_state == IDLE) begin
      w_we    = bus.we;
      w_size  = norm_size(bus.size);
      w_addr  = bus.addr[AW+1:0];
      w_wdata = bus.wdata;
`ifdef MEM_RESP_ERR_EN
      w_err = ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00)) ||
              ((w_size == SZ_HALF) && w_addr[0]);
`else
      w_err = 1'b0;
      if (w_size == SZ_WORD) w_addr[1:0] = 2'b00;
      else if (w_size == SZ_HALF) w_addr[0] = 1'b0;
`endif
    end
  end

  assign w_sub     = (w_size != SZ_WORD);
  assign w_sh      = {w_addr[1:0], 3'b000};
  assign w_mask    = lane_mask(w_size);
  assign w_lane_rd = (w_mem_rd >> w_sh) & w_mask;
  assign w_mem_wd  = (r_state == MERGE) ?
    ((w_mem_rd & ~(w_mask << w_sh)) |
     ((w_wdata & w_mask) << w_sh)) : w_wdata;

  always_comb begin
    w_after  = (w_we && w_sub && !w_err) ? MERGE : RESP;
    w_next   = r_state;
    w_mem_we = 1'b0;
    unique case (r_state)
      IDLE:    if (bus.req)
                 w_next = (WAIT_CYCLES != 0) ? WAIT : w_after;
      WAIT:    if (r_cnt == W_LAST) w_next = w_after;
      MERGE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state == MERGE)
      w_mem_we = 1'b1;
    else if (r_state != RESP && w_next == RESP)
      w_mem_we = w_we && !w_sub && !w_err;
    w_mem_we = w_mem_we & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SZ_WORD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (r_state == IDLE && bus.req) begin
        r_we    <= w_we;
        r_err   <= w_err;
        r_size  <= w_size;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (w_next == RESP && r_state != RESP && !w_we)
        r_rdata <= w_err ? '0 : w_lane_rd;
    end
  end

  mem_bank #(.AW(AW)) u_bank (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (w_mem_wd),
    .o_rdata (w_mem_rd)
  );

  assign bus.rdata = r_rdata;
  assign bus.ready = (r_state == RESP);
  assign bus.busy  = (r_state != IDLE);
`ifdef MEM_RESP_ERR_EN
  assign bus.err   = bus.ready & r_err;
`else
  assign bus.err   = 1'b0;
`endif

endmodule
